aes_core_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer that shares a single AES_top encryption core between two requesters. It accepts a plaintext/key pair from one requester at a time and drives the core's enable, data and key inputs. It collects the core's valid-qualified ciphertext, or raises an error on timeout, and returns the result to the granted requester over a valid/ready response channel. It sits between the requesting engines and AES_top, and is the only block that drives the core's inputs.

---
 rtl/aes_core_arbiter.sv | 93 +++++++++
 tb/tb_aes_core_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: round-robin sharing of one AES core between two requesters,
// with a timeout abort and a valid/ready response channel per port.
module aes_core_arbiter #(
    parameter int TIMEOUT_CYC = 64,
    parameter int GAP_CYC     = 2
) (
    input  logic         AES_clk,
    input  logic         AES_rst,
    input  logic         req0_valid,
    input  logic [127:0] req0_data,
    input  logic [127:0] req0_key,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [127:0] req1_data,
    input  logic [127:0] req1_key,
    output logic         req1_ready,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_err,
    output logic         core_en,
    output logic [127:0] core_data_in,
    output logic [127:0] core_key_in,
    input  logic [127:0] core_data_out,
    input  logic         core_data_out_valid,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, RUN, RESP, GAP} state_t;
    state_t       state;
    logic [127:0] op_data, op_key;
    logic         gnt, last_grant;
    logic [7:0]   cnt;
    logic         g0, g1;
    // On a tie the port not served last wins
    assign g0 = req0_valid && (!req1_valid || last_grant);
    assign g1 = req1_valid && (!req0_valid || !last_grant);
    assign req0_ready   = !AES_rst && state == IDLE && g0;
    assign req1_ready   = !AES_rst && state == IDLE && g1;
    assign core_en      = state == RUN;
    assign busy         = state != IDLE;
    assign rsp0_valid   = state == RESP && !gnt;
    assign rsp1_valid   = state == RESP && gnt;
    assign core_data_in = op_data;
    assign core_key_in  = op_key;
    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) begin
            state      <= IDLE;
            op_data    <= '0;
            op_key     <= '0;
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (g0 || g1) begin
                    op_data    <= g1 ? req1_data : req0_data;
                    op_key     <= g1 ? req1_key : req0_key;
                    gnt        <= g1;
                    last_grant <= g1;
                    cnt        <= '0;
                    state      <= RUN;
                end
                RUN: begin
                    cnt <= cnt + 8'd1;
                    // A valid in the timeout cycle still counts as success
                    if (core_data_out_valid) begin
                        rsp_data <= core_data_out;
                        rsp_err  <= 1'b0;
                        state    <= RESP;
                    end else if (cnt == 8'(TIMEOUT_CYC - 1)) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        state    <= RESP;
                    end
                end
                RESP: if (gnt ? rsp1_ready : rsp0_ready) begin
                    cnt   <= '0;
                    state <= GAP;
                end
                GAP: begin
                    if (cnt == 8'(GAP_CYC - 1))
                        state <= IDLE;
                    else
                        cnt <= cnt + 8'd1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_core_arbiter.sv
// tb_aes_core_arbiter: directed bench with a data^key core stub of
// programmable latency, plus a negedge monitor that tallies handshakes.
module tb_aes_core_arbiter;
    logic         clk, rst;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [127:0] req0_data, req0_key, req1_data, req1_key;
    logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [127:0] rsp_data, core_data_in, core_key_in, core_data_out;
    logic         rsp_err, core_en, core_data_out_valid, busy;
    logic         never, spur;
    int           lat;
    logic [7:0]   sc;

    aes_core_arbiter dut (
        .AES_clk(clk), .AES_rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_key(req0_key), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_key(req1_key), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .core_en(core_en), .core_data_in(core_data_in), .core_key_in(core_key_in),
        .core_data_out(core_data_out), .core_data_out_valid(core_data_out_valid),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stub: valid in the lat-th consecutive core_en cycle
    always @(posedge clk or posedge rst)
        if (rst) sc <= '0;
        else sc <= core_en ? sc + 8'd1 : 8'd0;
    assign core_data_out       = spur ? {128{1'b1}} : core_data_in ^ core_key_in;
    assign core_data_out_valid = (core_en && sc == 8'(lat - 1) && !never) || spur;

    int           cyc, n_r0, n_r1, n_en, n_v0, n_v1, n_both, hs_cyc;
    int           acc_c[$];
    logic         acc_i[$];
    logic [127:0] last_rsp;
    logic         last_err;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (req0_ready) begin n_r0 <= n_r0 + 1; acc_c.push_back(cyc); acc_i.push_back(1'b0); end
        if (req1_ready) begin n_r1 <= n_r1 + 1; acc_c.push_back(cyc); acc_i.push_back(1'b1); end
        if (core_en) n_en <= n_en + 1;
        if (rsp0_valid) n_v0 <= n_v0 + 1;
        if (rsp1_valid) n_v1 <= n_v1 + 1;
        if (rsp0_valid && rsp1_valid) n_both <= n_both + 1;
        if (rsp0_valid || rsp1_valid) begin last_rsp <= rsp_data; last_err <= rsp_err; end
        if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) hs_cyc <= cyc;
    end

    int vecs, errs;
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic wait_acc(input int base, input string tag);
        int k;
        for (k = 0; k < 100 && acc_c.size() <= base; k++) cyc_wait(1);
        chk(tag, 128'(acc_c.size() > base), 128'd1);
    endtask

    int s_r0, s_r1, s_en, s_v0, s_v1, s_both, b, bad;
    logic [127:0] d, k;

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; never = 1'b0; spur = 1'b0; lat = 11;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_data = '0; req0_key = '0; req1_data = '0; req1_key = '0;
        cyc_wait(3);
        chk("rst_outs", {core_en, busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready, rsp_err}, '0);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_core_in", core_data_in | core_key_in, '0);
        rst = 1'b0;
        cyc_wait(1);

        // Single operation from req0
        s_r0 = n_r0; s_en = n_en; s_v0 = n_v0; s_v1 = n_v1; b = acc_c.size();
        req0_data = 128'h000000c3_00000000_00000000_00000000;
        req0_key  = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
        req0_valid = 1; rsp0_ready = 1;
        wait_acc(b, "t1_accept");
        req0_valid = 0;
        cyc_wait(30);
        chk("t1_ready_pulses", 128'(n_r0 - s_r0), 128'd1);
        chk("t1_en_cycles", 128'(n_en - s_en), 128'd11);
        chk("t1_rsp0_cycles", 128'(n_v0 - s_v0), 128'd1);
        chk("t1_rsp1_cycles", 128'(n_v1 - s_v1), 128'd0);
        chk("t1_rsp_data", last_rsp, 128'haa2bdb83_bff6a5e8_caa9ba3e_bc1e2acc);
        chk("t1_rsp_err", 128'(last_err), 128'd0);

        // Both ports valid from reset: strict alternation, 15-cycle spacing
        rst = 1;
        req0_data = 128'h11; req0_key = 128'h0f;
        req1_data = 128'h2200; req1_key = 128'h0f0f;
        req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
        cyc_wait(2);
        s_v0 = n_v0; s_v1 = n_v1; s_both = n_both; b = acc_c.size();
        rst = 0;
        wait_acc(b + 3, "t2_four_accepts");
        req0_valid = 0; req1_valid = 0;
        cyc_wait(20);
        if (acc_c.size() >= b + 4) begin
            chk("t2_grant_ids", {acc_i[b], acc_i[b+1], acc_i[b+2], acc_i[b+3]}, 128'b0101);
            chk("t2_space01", 128'(acc_c[b+1] - acc_c[b]), 128'd15);
            chk("t2_space12", 128'(acc_c[b+2] - acc_c[b+1]), 128'd15);
            chk("t2_space23", 128'(acc_c[b+3] - acc_c[b+2]), 128'd15);
        end
        chk("t2_rsp0_count", 128'(n_v0 - s_v0), 128'd2);
        chk("t2_rsp1_count", 128'(n_v1 - s_v1), 128'd2);
        chk("t2_last_data", last_rsp, 128'h2d0f);
        chk("t2_no_dual_valid", 128'(n_both - s_both), 128'd0);

        // Timeout, then a normal operation
        never = 1;
        s_en = n_en; s_v0 = n_v0; b = acc_c.size();
        req0_data = 128'h5a5a; req0_key = 128'h0101; req0_valid = 1;
        wait_acc(b, "t3_accept");
        req0_valid = 0;
        cyc_wait(80);
        chk("t3_en_cycles", 128'(n_en - s_en), 128'd64);
        chk("t3_rsp0_count", 128'(n_v0 - s_v0), 128'd1);
        chk("t3_err", 128'(last_err), 128'd1);
        chk("t3_data_zero", last_rsp, '0);
        never = 0;
        s_en = n_en; b = acc_c.size();
        req0_data = 128'hc0ffee; req0_key = 128'h00ff00; req0_valid = 1;
        wait_acc(b, "t3_accept2");
        req0_valid = 0;
        cyc_wait(30);
        chk("t3_en_cycles2", 128'(n_en - s_en), 128'd11);
        chk("t3_data2", last_rsp, 128'hc000ee);
        chk("t3_err2", 128'(last_err), 128'd0);

        // Stalled response on port 1 with a pending req0 and spurious core valids
        rsp1_ready = 0; b = acc_c.size();
        req1_data = 128'h1234_5678; req1_key = 128'hffff_0000; req1_valid = 1;
        wait_acc(b, "t4_accept1");
        req1_valid = 0;
        bad = 0;
        for (int i = 0; i < 30 && !rsp1_valid; i++) cyc_wait(1);
        chk("t4_rsp1_rises", 128'(rsp1_valid), 128'd1);
        s_r0 = n_r0; b = acc_c.size();
        req0_data = 128'h77; req0_key = 128'h70; req0_valid = 1;
        for (int i = 0; i < 20; i++) begin
            spur = (i == 3);
            if (rsp_data !== 128'hedcb_5678 || core_en || !rsp1_valid || rsp0_valid) bad++;
            cyc_wait(1);
        end
        spur = 0;
        chk("t4_stall_stable", 128'(bad), 128'd0);
        chk("t4_no_req0_ready", 128'(n_r0 - s_r0), 128'd0);
        rsp1_ready = 1;
        cyc_wait(1);
        rsp1_ready = 0; spur = 1;
        cyc_wait(1);
        spur = 0;
        wait_acc(b, "t4_accept0");
        req0_valid = 0;
        if (acc_c.size() > b) begin
            chk("t4_accept_time", 128'(acc_c[b] - hs_cyc), 128'd3);
            chk("t4_accept_id", 128'(acc_i[b]), 128'd0);
        end
        cyc_wait(20);
        chk("t4_next_data", last_rsp, 128'h07);

        // Asynchronous reset in the middle of RUN
        b = acc_c.size();
        req0_data = 128'habc; req0_key = 128'h0; req0_valid = 1;
        wait_acc(b, "t5_accept");
        req0_valid = 0;
        cyc_wait(4);
        req0_valid = 1; req1_valid = 1;
        req0_data = 128'h100; req0_key = 128'h001;
        req1_data = 128'h200; req1_key = 128'h002;
        s_v0 = n_v0; s_v1 = n_v1;
        #1 rst = 1;
        #1 chk("t5_async_zero", {core_en, busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready}, '0);
        cyc_wait(2);
        b = acc_c.size();
        rst = 0;
        wait_acc(b, "t5_accept_after");
        req0_valid = 0; req1_valid = 0;
        if (acc_c.size() > b) chk("t5_first_grant", 128'(acc_i[b]), 128'd0);
        cyc_wait(30);
        chk("t5_rsp0_count", 128'(n_v0 - s_v0), 128'd1);
        chk("t5_rsp1_count", 128'(n_v1 - s_v1), 128'd0);
        chk("t5_data", last_rsp, 128'h101);

        // Core valid lands exactly on the timeout cycle
        lat = 64;
        s_en = n_en; b = acc_c.size();
        req0_data = 128'h8888; req0_key = 128'h0808; req0_valid = 1;
        wait_acc(b, "t6_accept");
        req0_valid = 0;
        cyc_wait(80);
        chk("t6_en_cycles", 128'(n_en - s_en), 128'd64);
        chk("t6_err", 128'(last_err), 128'd0);
        chk("t6_data", last_rsp, 128'h8080);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
